lspc_video_timing: RTL and testbench



---
 rtl/lspc_timing_pkg.sv | 22 ++
 rtl/lspc_modcnt.sv | 54 +++++
 rtl/lspc_video_timing.sv | 141 ++++++++++++++
 tb/tb_lspc_video_timing.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lspc_timing_pkg.sv
// Shared constants for the LSPC raster timing generator.
// Holds the default line/frame geometry (24 MHz master clock, 4 CK per
// pixel) and the widths of the prescaler and beam counters.
package lspc_timing_pkg;

    localparam int H_W   = 9;   // horizontal beam counter width
    localparam int V_W   = 9;   // vertical beam counter width
    localparam int DIV_W = 2;   // pixel prescaler width (divide by 4)

    // Default horizontal geometry, in pixels.
    localparam int H_TOTAL_DEF  = 384;
    localparam int HS_END_DEF   = 28;
    localparam int HB_END_DEF   = 56;
    localparam int HB_START_DEF = 376;

    // Default vertical geometry, in lines.
    localparam int V_TOTAL_DEF  = 264;
    localparam int VS_END_DEF   = 8;
    localparam int VB_END_DEF   = 16;
    localparam int VB_START_DEF = 240;

endpackage

// File: rtl/lspc_modcnt.sv
// Modulo-MOD up-counter, falling-edge clocked, asynchronous active-low clear.
// Ports:
//   clk_i   - clock; state updates on the falling edge
//   rst_ni  - asynchronous active-low clear (count returns to 0)
//   en_i    - advance by one on this edge
//   cnt_o   - registered count, 0..MOD-1
//   nxt_o   - value the count takes on the next falling edge
//   wrap_o  - high while en_i is set and the count sits at MOD-1; it is a
//             decode of the register plus the enable, so it is a single
//             AND term with no adder in its path
module lspc_modcnt #(
    parameter int WIDTH = 2,
    parameter int MOD   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic [WIDTH-1:0] nxt_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (at_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign nxt_o  = cnt_d;
    assign wrap_o = en_i & at_last;

endmodule

// File: rtl/lspc_video_timing.sv
// LSPC horizontal/vertical raster timing generator.
// A divide-by-4 prescaler produces the pixel enable; H counts pixels and V
// counts lines. Sync/blank strobes are registered from the counters' next
// values so each strobe flips on the same falling edge as the count it
// decodes. All state is negative-edge with asynchronous active-low clear.
// Ports:
//   CK        - 24 MHz master clock (falling-edge active)
//   CL        - asynchronous active-low clear
//   PCK_EN    - one CK in four, marks a pixel step
//   H, V      - beam position
//   nHSYNC    - low for H < HS_END
//   nHBLANK   - high for HB_END <= H < HB_START
//   nVSYNC    - low for V < VS_END
//   nVBLANK   - high for VB_END <= V < VB_START
//   LINE_END  - pixel step at H = H_TOTAL-1
//   FRAME_END - LINE_END on the last line
module lspc_video_timing
    import lspc_timing_pkg::*;
#(
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int HS_END   = HS_END_DEF,
    parameter int HB_END   = HB_END_DEF,
    parameter int HB_START = HB_START_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int VS_END   = VS_END_DEF,
    parameter int VB_END   = VB_END_DEF,
    parameter int VB_START = VB_START_DEF
) (
    input  logic           CK,
    input  logic           CL,
    output logic           PCK_EN,
    output logic [H_W-1:0] H,
    output logic [V_W-1:0] V,
    output logic           nHSYNC,
    output logic           nHBLANK,
    output logic           nVSYNC,
    output logic           nVBLANK,
    output logic           LINE_END,
    output logic           FRAME_END
);

    // Geometry legality, rejected at elaboration.
    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
        $error("lspc_video_timing: H_TOTAL and V_TOTAL must not exceed 512");
    end
    if (!(HS_END < HB_END && HB_END < HB_START && HB_START <= H_TOTAL)) begin : g_bad_h
        $error("lspc_video_timing: need HS_END < HB_END < HB_START <= H_TOTAL");
    end
    if (!(VS_END < VB_END && VB_END < VB_START && VB_START <= V_TOTAL)) begin : g_bad_v
        $error("lspc_video_timing: need VS_END < VB_END < VB_START <= V_TOTAL");
    end

    // Compares are one bit wider than the counters so a bound of 512 is
    // representable and still compares unsigned.
    localparam logic [H_W:0] HS_END_C   = (H_W+1)'(HS_END);
    localparam logic [H_W:0] HB_END_C   = (H_W+1)'(HB_END);
    localparam logic [H_W:0] HB_START_C = (H_W+1)'(HB_START);
    localparam logic [V_W:0] VS_END_C   = (V_W+1)'(VS_END);
    localparam logic [V_W:0] VB_END_C   = (V_W+1)'(VB_END);
    localparam logic [V_W:0] VB_START_C = (V_W+1)'(VB_START);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             pck_en;
    logic [H_W-1:0]   h_cnt;
    logic [H_W-1:0]   h_nxt;
    logic             h_wrap;
    logic [V_W-1:0]   v_cnt;
    logic [V_W-1:0]   v_nxt;
    logic             v_wrap;

    // The prescaler's wrap (enable tied high) is exactly DIV == 3.
    lspc_modcnt #(.WIDTH(DIV_W), .MOD(4)) u_div (
        .clk_i  (CK),
        .rst_ni (CL),
        .en_i   (1'b1),
        .cnt_o  (div_cnt),
        .nxt_o  (div_nxt),
        .wrap_o (pck_en)
    );

    lspc_modcnt #(.WIDTH(H_W), .MOD(H_TOTAL)) u_h (
        .clk_i  (CK),
        .rst_ni (CL),
        .en_i   (pck_en),
        .cnt_o  (h_cnt),
        .nxt_o  (h_nxt),
        .wrap_o (h_wrap)
    );

    lspc_modcnt #(.WIDTH(V_W), .MOD(V_TOTAL)) u_v (
        .clk_i  (CK),
        .rst_ni (CL),
        .en_i   (h_wrap),
        .cnt_o  (v_cnt),
        .nxt_o  (v_nxt),
        .wrap_o (v_wrap)
    );

    // The prescaler position and its look-ahead have no consumer beyond
    // the pixel enable.
    logic div_unused;
    assign div_unused = ^{div_cnt, div_nxt};

    logic nhsync_q, nhblank_q, nvsync_q, nvblank_q;
    logic nhsync_d, nhblank_d, nvsync_d, nvblank_d;

    always_comb begin
        nhsync_d  = !({1'b0, h_nxt} < HS_END_C);
        nhblank_d = ({1'b0, h_nxt} >= HB_END_C) && ({1'b0, h_nxt} < HB_START_C);
        nvsync_d  = !({1'b0, v_nxt} < VS_END_C);
        nvblank_d = ({1'b0, v_nxt} >= VB_END_C) && ({1'b0, v_nxt} < VB_START_C);
    end

    always_ff @(negedge CK or negedge CL) begin
        if (!CL) begin
            nhsync_q  <= 1'b0;
            nhblank_q <= 1'b0;
            nvsync_q  <= 1'b0;
            nvblank_q <= 1'b0;
        end else begin
            nhsync_q  <= nhsync_d;
            nhblank_q <= nhblank_d;
            nvsync_q  <= nvsync_d;
            nvblank_q <= nvblank_d;
        end
    end

    assign PCK_EN    = pck_en;
    assign H         = h_cnt;
    assign V         = v_cnt;
    assign nHSYNC    = nhsync_q;
    assign nHBLANK   = nhblank_q;
    assign nVSYNC    = nvsync_q;
    assign nVBLANK   = nvblank_q;
    // Both are AND terms over register bits only (the wraps are decodes of
    // DIV/H/V against constants gated by the previous stage's decode).
    assign LINE_END  = h_wrap;
    assign FRAME_END = v_wrap;

endmodule

// File: tb/tb_lspc_video_timing.sv
// Directed bench for lspc_video_timing: one instance with the default
// geometry and one with a reduced geometry (16 px x 8 lines) so frame-level
// behaviour fits in a short run.
module tb_lspc_video_timing;

  // ---------------- clock / reset ----------------
  logic ck;
  logic cl;
  logic cl_s;

  initial begin
    ck = 1'b1;
    forever #21 ck = ~ck;
  end

  // Default-geometry DUT outputs.
  logic       pck_d, nhs_d, nhb_d, nvs_d, nvb_d, le_d, fe_d;
  logic [8:0] h_d, v_d;
  // Small-geometry DUT outputs.
  logic       pck_s, nhs_s, nhb_s, nvs_s, nvb_s, le_s, fe_s;
  logic [8:0] h_s, v_s;

  lspc_video_timing dut (
    .CK(ck), .CL(cl), .PCK_EN(pck_d), .H(h_d), .V(v_d),
    .nHSYNC(nhs_d), .nHBLANK(nhb_d), .nVSYNC(nvs_d), .nVBLANK(nvb_d),
    .LINE_END(le_d), .FRAME_END(fe_d)
  );

  lspc_video_timing #(
    .H_TOTAL(16), .HS_END(2), .HB_END(4), .HB_START(12),
    .V_TOTAL(8), .VS_END(1), .VB_END(2), .VB_START(6)
  ) dut_s (
    .CK(ck), .CL(cl_s), .PCK_EN(pck_s), .H(h_s), .V(v_s),
    .nHSYNC(nhs_s), .nHBLANK(nhb_s), .nVSYNC(nvs_s), .nVBLANK(nvb_s),
    .LINE_END(le_s), .FRAME_END(fe_s)
  );

  logic [24:0] all_d, all_s;
  assign all_d = {pck_d, h_d, v_d, nhs_d, nhb_d, nvs_d, nvb_d, le_d, fe_d};
  assign all_s = {pck_s, h_s, v_s, nhs_s, nhb_s, nvs_s, nvb_s, le_s, fe_s};

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  int ek    = 0;   // falling edges since CL released

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the given falling-edge count, then sample 5 units later.
  task automatic adv_to(input int target);
    repeat (target - ek) @(negedge ck);
    ek = target;
    #5;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  int fe_cnt, vb_hi_cnt, vs_lo_cnt;

  initial begin
    cl = 1'b1;
    cl_s = 1'b1;
    #1;
    cl = 1'b0;
    cl_s = 1'b0;
    repeat (10) @(negedge ck);
    #5;
    chk("reset_all_default", {7'd0, all_d}, 32'd0);
    chk("reset_all_small", {7'd0, all_s}, 32'd0);

    @(posedge ck);
    cl = 1'b1;
    cl_s = 1'b1;
    ek = 0;

    adv_to(2);
    chk("pck_edge2", {31'd0, pck_d}, 32'd0);
    adv_to(3);
    chk("pck_edge3", {31'd0, pck_d}, 32'd1);
    chk("h_edge3", {23'd0, h_d}, 32'd0);
    adv_to(4);
    chk("pck_edge4", {31'd0, pck_d}, 32'd0);
    chk("h_edge4", {23'd0, h_d}, 32'd1);
    adv_to(7);
    chk("pck_edge7", {31'd0, pck_d}, 32'd1);

    adv_to(7);
    chk("s_nhsync_h1", {31'd0, nhs_s}, 32'd0);
    adv_to(8);
    chk("s_nhsync_h2", {31'd0, nhs_s}, 32'd1);
    adv_to(16);
    chk("s_nhblank_h4", {31'd0, nhb_s}, 32'd1);
    adv_to(48);
    chk("s_nhblank_h12", {31'd0, nhb_s}, 32'd0);
    adv_to(63);
    chk("s_line_end", {31'd0, le_s}, 32'd1);
    chk("s_frame_end_l0", {31'd0, fe_s}, 32'd0);
    adv_to(64);
    chk("s_h_wrap", {23'd0, h_s}, 32'd0);
    chk("s_v_line1", {23'd0, v_s}, 32'd1);
    chk("s_nvsync_v1", {31'd0, nvs_s}, 32'd1);

    adv_to(111);
    chk("nhsync_h27", {31'd0, nhs_d}, 32'd0);
    adv_to(112);
    chk("h_edge112", {23'd0, h_d}, 32'd28);
    chk("nhsync_h28", {31'd0, nhs_d}, 32'd1);
    adv_to(127);
    chk("s_nvblank_v1", {31'd0, nvb_s}, 32'd0);
    adv_to(128);
    chk("s_nvblank_v2", {31'd0, nvb_s}, 32'd1);
    adv_to(223);
    chk("nhblank_h55", {31'd0, nhb_d}, 32'd0);
    adv_to(224);
    chk("nhblank_h56", {31'd0, nhb_d}, 32'd1);
    adv_to(384);
    chk("s_nvblank_v6", {31'd0, nvb_s}, 32'd0);

    // Last pixel of the small frame, then the simultaneous H/V wrap.
    adv_to(511);
    chk("s_last_h", {23'd0, h_s}, 32'd15);
    chk("s_last_v", {23'd0, v_s}, 32'd7);
    chk("s_last_pck", {31'd0, pck_s}, 32'd1);
    chk("s_frame_end", {31'd0, fe_s}, 32'd1);
    chk("s_nvsync_v7", {31'd0, nvs_s}, 32'd1);
    adv_to(512);
    chk("s_wrap_h", {23'd0, h_s}, 32'd0);
    chk("s_wrap_v", {23'd0, v_s}, 32'd0);
    chk("s_wrap_nhsync", {31'd0, nhs_s}, 32'd0);
    chk("s_wrap_nvsync", {31'd0, nvs_s}, 32'd0);
    chk("s_wrap_fe", {31'd0, fe_s}, 32'd0);

    // One full small frame: every state visited once.
    fe_cnt = 0;
    vb_hi_cnt = 0;
    vs_lo_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge ck);
      #5;
      if (fe_s) fe_cnt++;
      if (nvb_s) vb_hi_cnt++;
      if (!nvs_s) vs_lo_cnt++;
    end
    ek = ek + 512;
    chk("s_frame_end_count", fe_cnt, 32'd1);
    chk("s_nvblank_high_ck", vb_hi_cnt, 32'd256);
    chk("s_nvsync_low_ck", vs_lo_cnt, 32'd64);
    chk("s_frame_v0", {23'd0, v_s}, 32'd0);

    // Mid-line clear of the small instance, between clock edges.
    adv_to(1236);
    chk("s_pre_clr_h", {23'd0, h_s}, 32'd5);
    chk("s_pre_clr_v", {23'd0, v_s}, 32'd3);
    chk("pre_clr_h_default", {23'd0, h_d}, 32'd309);
    #5;
    cl_s = 1'b0;
    #1;
    chk("s_clr_async", {7'd0, all_s}, 32'd0);
    #2;
    cl_s = 1'b1;
    #1;
    chk("s_clr_held", {7'd0, all_s}, 32'd0);
    @(negedge ck);
    ek = ek + 1;
    #5;
    chk("s_restart_e1_pck", {31'd0, pck_s}, 32'd0);
    chk("s_restart_e1_h", {23'd0, h_s}, 32'd0);
    chk("clr_isolated_h", {23'd0, h_d}, 32'd309);
    adv_to(1239);
    chk("s_restart_e3_pck", {31'd0, pck_s}, 32'd1);
    chk("pck_default_1239", {31'd0, pck_d}, 32'd1);
    adv_to(1240);
    chk("s_restart_e4_h", {23'd0, h_s}, 32'd1);
    chk("s_restart_e4_pck", {31'd0, pck_s}, 32'd0);
    chk("h_default_1240", {23'd0, h_d}, 32'd310);

    // Default line end.
    adv_to(1503);
    chk("nhblank_h375", {31'd0, nhb_d}, 32'd1);
    adv_to(1504);
    chk("nhblank_h376", {31'd0, nhb_d}, 32'd0);
    chk("h_edge1504", {23'd0, h_d}, 32'd376);
    adv_to(1534);
    chk("line_end_1534", {31'd0, le_d}, 32'd0);
    adv_to(1535);
    chk("line_end_1535", {31'd0, le_d}, 32'd1);
    chk("h_edge1535", {23'd0, h_d}, 32'd383);
    chk("frame_end_line0", {31'd0, fe_d}, 32'd0);
    adv_to(1536);
    chk("line_end_1536", {31'd0, le_d}, 32'd0);
    chk("h_wrap_default", {23'd0, h_d}, 32'd0);
    chk("v_line1_default", {23'd0, v_d}, 32'd1);
    chk("nvsync_v1", {31'd0, nvs_d}, 32'd0);

    // Vertical strobes on the default geometry.
    adv_to(12287);
    chk("v_line7", {23'd0, v_d}, 32'd7);
    chk("nvsync_v7", {31'd0, nvs_d}, 32'd0);
    adv_to(12288);
    chk("v_line8", {23'd0, v_d}, 32'd8);
    chk("nvsync_v8", {31'd0, nvs_d}, 32'd1);
    adv_to(24575);
    chk("nvblank_v15", {31'd0, nvb_d}, 32'd0);
    adv_to(24576);
    chk("nvblank_v16", {31'd0, nvb_d}, 32'd1);
    chk("v_line16", {23'd0, v_d}, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
